// File: rtl/rooth_pipe_stage_if.sv
// Handshake bundle for the rooth pipeline boundary register: upstream beat,
// downstream beat and occupancy, with the stage as slave.
interface rooth_pipe_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [1:0]            count_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output count_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  count_o
    );
endinterface

// File: rtl/rooth_pipe_stage.sv
// Generic valid/ready pipeline boundary register for the rooth core with an
// optional two-entry skid buffer and a synchronous flush to a bubble pattern.
module rooth_pipe_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VAL = {DATA_WIDTH{1'b0}},
    parameter bit                    SKID_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    rooth_pipe_stage_if.slave bus
);

    // Encoding mirrors {m_valid, s_valid} so the valid bits fall out of the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } state_e;

    state_e                state_r;
    state_e                state_s;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic [DATA_WIDTH-1:0] m_data_s;
    logic [DATA_WIDTH-1:0] s_data_r;
    logic [DATA_WIDTH-1:0] s_data_s;
    logic [1:0]            count_r;
    logic [1:0]            count_s;
    logic                  m_valid_s;
    logic                  s_valid_s;
    logic                  in_ready_s;
    logic                  in_fire_s;
    logic                  out_fire_s;

    assign m_valid_s  = (state_r != ST_EMPTY);
    assign s_valid_s  = (state_r == ST_TWO);
    assign in_fire_s  = bus.in_valid_i & in_ready_s;
    assign out_fire_s = m_valid_s & bus.out_ready_i;

    // Upstream ready: registered-only with the skid buffer, pass-through without.
    always_comb begin
        in_ready_s = 1'b0;
        if (SKID_EN) begin
            in_ready_s = ~s_valid_s;
        end else begin
            in_ready_s = ~m_valid_s | bus.out_ready_i;
        end
    end

    // Next-state and next-data selection; flush overrides every transition.
    always_comb begin
        state_s  = state_r;
        m_data_s = m_data_r;
        s_data_s = s_data_r;
        if (flush_i) begin
            state_s  = ST_EMPTY;
            m_data_s = BUBBLE_VAL;
            s_data_s = BUBBLE_VAL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_s  = ST_ONE;
                        m_data_s = bus.in_data_i;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_s  = ST_ONE;
                        m_data_s = bus.in_data_i;
                    end else if (out_fire_s) begin
                        state_s  = ST_EMPTY;
                        m_data_s = BUBBLE_VAL;
                    end else if (in_fire_s && SKID_EN) begin
                        state_s  = ST_TWO;
                        s_data_s = bus.in_data_i;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // Skid entry moves forward; ready recovers on the following cycle.
                    if (out_fire_s) begin
                        state_s  = ST_ONE;
                        m_data_s = s_data_r;
                        s_data_s = BUBBLE_VAL;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s  = ST_EMPTY;
                    m_data_s = BUBBLE_VAL;
                    s_data_s = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Occupancy of the next state, registered alongside the entries.
    always_comb begin
        count_s = 2'd0;
        case (state_s)
            ST_EMPTY: count_s = 2'd0;
            ST_ONE:   count_s = 2'd1;
            ST_TWO:   count_s = 2'd2;
            default:  count_s = 2'd0;
        endcase
    end

    // State, payload and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_EMPTY;
            m_data_r <= BUBBLE_VAL;
            s_data_r <= BUBBLE_VAL;
            count_r  <= 2'd0;
        end else begin
            state_r  <= state_s;
            m_data_r <= m_data_s;
            s_data_r <= s_data_s;
            count_r  <= count_s;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = m_valid_s;
    assign bus.out_data_o  = m_data_r;
    assign bus.count_o     = count_r;

endmodule

// File: tb/tb_rooth_pipe_stage.sv
// Self-checking bench: a skid instance (bubble 0x3) and a single-register
// instance (bubble 0x0), with per-beat scoreboards plus directed state checks.
module tb_rooth_pipe_stage;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic sflush = 1'b0;
    logic nflush = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] sq[$];
    logic [31:0] nq[$];
    logic [31:0] s_exp;
    logic [31:0] n_exp;
    logic [35:0] obs;
    logic [35:0] want;

    rooth_pipe_stage_if #(.DATA_WIDTH(32)) s_if ();
    rooth_pipe_stage_if #(.DATA_WIDTH(32)) n_if ();

    rooth_pipe_stage #(.DATA_WIDTH(32), .BUBBLE_VAL(32'h0000_0003), .SKID_EN(1'b1)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (sflush),
        .bus     (s_if.slave)
    );

    rooth_pipe_stage #(.DATA_WIDTH(32), .BUBBLE_VAL(32'h0000_0000), .SKID_EN(1'b0)) u_noskid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (nflush),
        .bus     (n_if.slave)
    );

    always #5 clk = ~clk;

    // {valid, count, ready, data} snapshots
    function automatic logic [35:0] s_stat();
        return {s_if.out_valid_o, s_if.count_o, s_if.in_ready_o, s_if.out_data_o};
    endfunction

    function automatic logic [35:0] n_stat();
        return {n_if.out_valid_o, n_if.count_o, n_if.in_ready_o, n_if.out_data_o};
    endfunction

    // Skid scoreboard: pop on out-fire, push on in-fire, drop everything on flush.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq.delete();
        end else begin
            if (s_if.out_valid_o && s_if.out_ready_i) begin
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL skid_sb_extra: got %h expected no beat", s_if.out_data_o);
                end else begin
                    s_exp = sq.pop_front();
                    if (s_if.out_data_o !== s_exp) begin
                        errors++;
                        $display("FAIL skid_sb_data: got %h expected %h", s_if.out_data_o, s_exp);
                    end
                end
            end
            if (sflush) sq.delete();
            else if (s_if.in_valid_i && s_if.in_ready_o) sq.push_back(s_if.in_data_i);
        end
    end

    // Single-register scoreboard, same rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nq.delete();
        end else begin
            if (n_if.out_valid_o && n_if.out_ready_i) begin
                checks++;
                if (nq.size() == 0) begin
                    errors++;
                    $display("FAIL noskid_sb_extra: got %h expected no beat", n_if.out_data_o);
                end else begin
                    n_exp = nq.pop_front();
                    if (n_if.out_data_o !== n_exp) begin
                        errors++;
                        $display("FAIL noskid_sb_data: got %h expected %h", n_if.out_data_o, n_exp);
                    end
                end
            end
            if (nflush) nq.delete();
            else if (n_if.in_valid_i && n_if.in_ready_o) nq.push_back(n_if.in_data_i);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        obs = s_stat(); want = {1'b0, 2'd0, 1'b1, 32'h0000_0003}; checks++;
        if (obs !== want) begin errors++; $display("FAIL reset_skid: got %h expected %h", obs, want); end
        obs = n_stat(); want = {1'b0, 2'd0, 1'b1, 32'h0000_0000}; checks++;
        if (obs !== want) begin errors++; $display("FAIL reset_noskid: got %h expected %h", obs, want); end
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        logic [31:0] beats [3];
        beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33;
        s_if.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_if.in_valid_i = 1'b1;
            s_if.in_data_i  = beats[i];
            @(negedge clk);
            obs = s_stat(); want = {1'b1, 2'd1, 1'b1, beats[i]}; checks++;
            if (obs !== want) begin errors++; $display("FAIL stream_%0d: got %h expected %h", i, obs, want); end
        end
        s_if.in_valid_i = 1'b0;
        s_if.in_data_i  = 32'hDEAD_0000;
        @(negedge clk);
        obs = s_stat(); want = {1'b0, 2'd0, 1'b1, 32'h0000_0003}; checks++;
        if (obs !== want) begin errors++; $display("FAIL empty_drain: got %h expected %h", obs, want); end
    endtask

    task automatic test_backpressure();
        s_if.out_ready_i = 1'b0;
        s_if.in_valid_i  = 1'b1;
        s_if.in_data_i   = 32'hA1;
        @(negedge clk);
        obs = s_stat(); want = {1'b1, 2'd1, 1'b1, 32'hA1}; checks++;
        if (obs !== want) begin errors++; $display("FAIL bp_one: got %h expected %h", obs, want); end
        s_if.in_data_i = 32'hA2;
        @(negedge clk);
        s_if.in_valid_i = 1'b0;
        obs = s_stat(); want = {1'b1, 2'd2, 1'b0, 32'hA1}; checks++;
        if (obs !== want) begin errors++; $display("FAIL bp_two: got %h expected %h", obs, want); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs = s_stat(); checks++;
            if (obs !== want) begin errors++; $display("FAIL bp_hold_%0d: got %h expected %h", i, obs, want); end
        end
        s_if.out_ready_i = 1'b1;
        @(negedge clk);
        obs = s_stat(); want = {1'b1, 2'd1, 1'b1, 32'hA2}; checks++;
        if (obs !== want) begin errors++; $display("FAIL bp_release: got %h expected %h", obs, want); end
        @(negedge clk);
        obs = s_stat(); want = {1'b0, 2'd0, 1'b1, 32'h0000_0003}; checks++;
        if (obs !== want) begin errors++; $display("FAIL bp_drained: got %h expected %h", obs, want); end
    endtask

    task automatic test_flush();
        s_if.out_ready_i = 1'b0;
        s_if.in_valid_i  = 1'b1;
        s_if.in_data_i   = 32'h51;
        @(negedge clk);
        s_if.in_data_i = 32'h52;
        @(negedge clk);
        obs = s_stat(); want = {1'b1, 2'd2, 1'b0, 32'h51}; checks++;
        if (obs !== want) begin errors++; $display("FAIL flush_pre: got %h expected %h", obs, want); end
        sflush = 1'b1;
        s_if.in_data_i = 32'hB0;
        @(negedge clk);
        sflush = 1'b0;
        s_if.in_valid_i = 1'b0;
        want = {1'b0, 2'd0, 1'b1, 32'h0000_0003};
        obs = s_stat(); checks++;
        if (obs !== want) begin errors++; $display("FAIL flush_two: got %h expected %h", obs, want); end
        s_if.out_ready_i = 1'b1;
        @(negedge clk);
        obs = s_stat(); checks++;
        if (obs !== want) begin errors++; $display("FAIL flush_no_b0: got %h expected %h", obs, want); end
        // Upstream handshake in the flush cycle is dropped.
        sflush = 1'b1;
        s_if.in_valid_i = 1'b1;
        s_if.in_data_i  = 32'hB1;
        @(negedge clk);
        sflush = 1'b0;
        s_if.in_valid_i = 1'b0;
        obs = s_stat(); checks++;
        if (obs !== want) begin errors++; $display("FAIL flush_discard: got %h expected %h", obs, want); end
        // Out-fire in the flush cycle still delivers (scoreboard pops 0x61).
        s_if.out_ready_i = 1'b0;
        s_if.in_valid_i  = 1'b1;
        s_if.in_data_i   = 32'h61;
        @(negedge clk);
        s_if.in_valid_i  = 1'b0;
        s_if.out_ready_i = 1'b1;
        sflush = 1'b1;
        @(negedge clk);
        sflush = 1'b0;
        obs = s_stat(); checks++;
        if (obs !== want) begin errors++; $display("FAIL flush_one_deliver: got %h expected %h", obs, want); end
    endtask

    task automatic test_async_reset();
        s_if.out_ready_i = 1'b0;
        s_if.in_valid_i  = 1'b1;
        s_if.in_data_i   = 32'h77;
        @(negedge clk);
        s_if.in_valid_i = 1'b0;
        obs = s_stat(); want = {1'b1, 2'd1, 1'b1, 32'h77}; checks++;
        if (obs !== want) begin errors++; $display("FAIL areset_pre: got %h expected %h", obs, want); end
        #2 rst_n = 1'b0;
        #1;
        obs = s_stat(); want = {1'b0, 2'd0, 1'b1, 32'h0000_0003}; checks++;
        if (obs !== want) begin errors++; $display("FAIL areset_now: got %h expected %h", obs, want); end
        @(negedge clk);
        rst_n = 1'b1;
        s_if.in_valid_i  = 1'b1;
        s_if.in_data_i   = 32'hC5;
        s_if.out_ready_i = 1'b1;
        @(negedge clk);
        s_if.in_valid_i = 1'b0;
        obs = s_stat(); want = {1'b1, 2'd1, 1'b1, 32'hC5}; checks++;
        if (obs !== want) begin errors++; $display("FAIL areset_c5: got %h expected %h", obs, want); end
        @(negedge clk);
        obs = s_stat(); want = {1'b0, 2'd0, 1'b1, 32'h0000_0003}; checks++;
        if (obs !== want) begin errors++; $display("FAIL areset_drain: got %h expected %h", obs, want); end
    endtask

    task automatic test_noskid();
        n_if.out_ready_i = 1'b0;
        n_if.in_valid_i  = 1'b1;
        n_if.in_data_i   = 32'hD1;
        @(negedge clk);
        obs = n_stat(); want = {1'b1, 2'd1, 1'b0, 32'hD1}; checks++;
        if (obs !== want) begin errors++; $display("FAIL noskid_full: got %h expected %h", obs, want); end
        n_if.in_data_i   = 32'hD2;
        n_if.out_ready_i = 1'b1;
        #1;
        obs = n_stat(); want = {1'b1, 2'd1, 1'b1, 32'hD1}; checks++;
        if (obs !== want) begin errors++; $display("FAIL noskid_ready_comb: got %h expected %h", obs, want); end
        @(negedge clk);
        n_if.in_valid_i = 1'b0;
        obs = n_stat(); want = {1'b1, 2'd1, 1'b1, 32'hD2}; checks++;
        if (obs !== want) begin errors++; $display("FAIL noskid_replace: got %h expected %h", obs, want); end
        @(negedge clk);
        obs = n_stat(); want = {1'b0, 2'd0, 1'b1, 32'h0000_0000}; checks++;
        if (obs !== want) begin errors++; $display("FAIL noskid_drain: got %h expected %h", obs, want); end
    endtask

    task automatic test_back_to_back();
        logic        s_pv = 1'b0;
        logic        s_pr = 1'b0;
        logic [31:0] s_pd = 32'h0;
        logic        n_pv = 1'b0;
        logic        n_pr = 1'b0;
        logic [31:0] n_pd = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (s_pv && !s_pr) begin
                checks++;
                if (s_if.out_valid_o !== 1'b1 || s_if.out_data_o !== s_pd) begin
                    errors++;
                    $display("FAIL skid_stall_hold: got %b/%h expected 1/%h", s_if.out_valid_o, s_if.out_data_o, s_pd);
                end
            end
            if (n_pv && !n_pr) begin
                checks++;
                if (n_if.out_valid_o !== 1'b1 || n_if.out_data_o !== n_pd) begin
                    errors++;
                    $display("FAIL noskid_stall_hold: got %b/%h expected 1/%h", n_if.out_valid_o, n_if.out_data_o, n_pd);
                end
            end
            checks++;
            if (n_if.count_o > 2'd1 || s_if.count_o > 2'd2) begin
                errors++;
                $display("FAIL count_range: got %0d/%0d expected <=2/<=1", s_if.count_o, n_if.count_o);
            end
            s_pv = s_if.out_valid_o; s_pd = s_if.out_data_o;
            n_pv = n_if.out_valid_o; n_pd = n_if.out_data_o;
            s_if.in_valid_i  = ($urandom_range(0, 3) != 0);
            s_if.in_data_i   = $urandom();
            s_if.out_ready_i = ($urandom_range(0, 2) != 0);
            n_if.in_valid_i  = ($urandom_range(0, 3) != 0);
            n_if.in_data_i   = $urandom();
            n_if.out_ready_i = ($urandom_range(0, 2) != 0);
            s_pr = s_if.out_ready_i;
            n_pr = n_if.out_ready_i;
            @(negedge clk);
        end
        s_if.in_valid_i  = 1'b0;
        n_if.in_valid_i  = 1'b0;
        s_if.out_ready_i = 1'b1;
        n_if.out_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (sq.size() != 0 || nq.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: got %0d/%0d pending expected 0/0", sq.size(), nq.size());
        end
    endtask

    initial begin
        s_if.in_valid_i  = 1'b0;
        s_if.in_data_i   = 32'h0;
        s_if.out_ready_i = 1'b0;
        n_if.in_valid_i  = 1'b0;
        n_if.in_data_i   = 32'h0;
        n_if.out_ready_i = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_noskid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rooth_pipe_stage.md
# rooth_pipe_stage

Parametrised pipeline boundary register for the rooth core. It replaces the fixed-field, flow-code-driven stage registers with a generic payload carried under a valid/ready handshake. It has an optional two-entry skid buffer, so upstream ready no longer depends combinationally on downstream ready. A synchronous flush loads a configurable bubble pattern. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB; the decoded control fields of each stage are concatenated into `in_data_i`.

## Interface
- `DATA_WIDTH`, 32: payload width in bits; legal range ≥1.
- `BUBBLE_VAL`, `{DATA_WIDTH{1'b0}}`: value driven on `out_data_o` after reset, after flush, and whenever the stage is empty. It encodes a NOP, for example `reg_wr_en=0` and result-select `2'b11`.
- `SKID_EN`, 1: 1 selects the two-entry skid buffer; 0 selects a single register.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush_i` input 1: synchronous flush; has the highest priority.
- `in_valid_i` input 1: upstream beat valid.
- `in_ready_o` output 1: stage can accept a beat.
- `in_data_i` input DATA_WIDTH: upstream payload.
- `out_valid_o` output 1: the beat in the main register is valid.
- `out_ready_i` input 1: downstream accepts.
- `out_data_o` output DATA_WIDTH: payload from the main register.
- `count_o` output 2: occupancy, 0 to 2.

## Operation
- Fire conditions:
  - In-fire = `in_valid_i & in_ready_o`.
  - Out-fire = `out_valid_o & out_ready_i`.
- Storage:
  - Main register M holds `m_valid` and `m_data`.
  - Skid register S holds `s_valid` and `s_data`, and exists only when `SKID_EN=1`.
- Ready, `SKID_EN=1`: `in_ready_o = ~s_valid`. It is a pure register output with no combinational path from `out_ready_i`.
- Ready, `SKID_EN=0`: `in_ready_o = ~m_valid | out_ready_i`. S is absent and `count_o` never exceeds 1.
- State machine for `SKID_EN=1`, with state = {`m_valid`, `s_valid`}:
  - EMPTY (0,0):
    - in-fire → ONE, M←in.
  - ONE (1,0):
    - in-fire and out-fire → ONE, M←in.
    - out-fire only → EMPTY, M←BUBBLE_VAL.
    - in-fire only → TWO, S←in.
    - neither → hold.
  - TWO (1,1), where `in_ready_o=0`:
    - out-fire → ONE, M←S, S←BUBBLE_VAL.
    - otherwise → hold.
- Flush (`flush_i=1` at the edge):
  - Next state is EMPTY. M and S data become BUBBLE_VAL and `count_o` becomes 0.
  - Any beat handshaking upstream in the same cycle is discarded.
  - A beat that out-fires in the same cycle is considered delivered.
  - Flush overrides every other transition.
- Stall: with `out_ready_i=0`, M is held bit-exact for any number of cycles. A valid `out_data_o` must not change until out-fire.
- Ordering: beats leave in acceptance order. There is no loss or duplication except on flush.
- `count_o` = `m_valid + s_valid`.

## Timing
- Reset values (asynchronous assertion): `out_valid_o=0`, `out_data_o=BUBBLE_VAL`, `count_o=0`, `in_ready_o=1`. S is cleared to BUBBLE_VAL.
- Reset deassertion: the first in-fire is allowed on the first rising edge after `rst_n` goes high.
- Latency: a beat accepted at edge N is visible on `out_*` after edge N, i.e. one cycle.
- Throughput: one beat per cycle when `out_ready_i` is held at 1.
- Ready after backpressure (`SKID_EN=1`): `in_ready_o` drops the cycle after S fills. It recovers the cycle after the first out-fire from TWO.
- Flush: `out_valid_o=0` and `in_ready_o=1` on the cycle after the flush edge.
- Reset mid-operation: both entries are lost immediately, without waiting for a clock.

## Test plan
- Streaming, `SKID_EN=1`, `DATA_WIDTH=32`: beats 0x11, 0x22, 0x33 on consecutive cycles with `out_ready_i=1` → they appear one cycle later, back-to-back, `count_o=1` throughout, and `in_ready_o` stays 1.
- Backpressure and skid: 0xA1 and 0xA2 accepted while `out_ready_i=0` → `count_o=2`, `in_ready_o=0`, `out_data_o=0xA1` held for 5 cycles. Release `out_ready_i` → 0xA1 then 0xA2 are delivered, and `in_ready_o=1` one cycle after the first delivery.
- Flush in TWO with `BUBBLE_VAL=0x0000_0003`: `flush_i` pulse while a new beat 0xB0 is offered → next cycle `out_valid_o=0`, `out_data_o=0x3`, `count_o=0`, and 0xB0 never appears.
- Asynchronous reset mid-stream: `rst_n` pulled low between edges while in ONE → outputs are at reset values immediately. After release, beat 0xC5 passes with 1-cycle latency.
- `SKID_EN=0`: `out_ready_i=0` with M full → `in_ready_o=0` in the same cycle. Raising `out_ready_i` → `in_ready_o=1` combinationally, and the new beat replaces the old one in a single cycle.
- Empty drain: after the last beat out-fires with no input → `out_data_o` returns to BUBBLE_VAL on the next cycle.
